// File: rtl/bcd_game_timer.sv
// bcd_game_timer: a prescaled decimal (BCD) up-counter for game timing.
// A prescaler divides CLOCK_50 by TICK_DIV. Each time it expires, the BCD
// count advances by one with a true decimal ripple. At all-9s the count
// either wraps to zero or saturates.
// Optional feature: define BCD_GAME_TIMER_HEX_EN to build per-digit
// active-low seven-segment decoders on hex. Without it, hex is held blank
// (all ones).
module bcd_game_timer #(
  parameter int DIGITS      = 4,
  parameter int TICK_DIV    = 50000000,
  parameter int LEVEL_DIGIT = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  saturate,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick,
  output logic                  wrap,
  output logic                  at_max,
  output logic                  fast_slow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int              PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PS_LAST = PW'(TICK_DIV - 1);

  typedef logic [4*DIGITS-1:0] bcd_t;

  logic [PW-1:0] ps_q, ps_d;
  bcd_t          bcd_q, bcd_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          all_nines;

  // Decimal ripple increment: a digit advances only when every lower digit
  // is 9, and a 9 that receives a carry rolls over to 0.
  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t       r;
    logic       carry;
    logic [3:0] d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic is_all_nines(input bcd_t v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) r = 1'b0;
    end
    return r;
  endfunction

  // Decode the all-9s condition from the registered count.
  always_comb begin
    all_nines = is_all_nines(bcd_q);
  end

  // Next-state logic: clear wins over counting, and enable gates everything else.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned; a missing default would infer a latch.
    ps_d   = ps_q;
    bcd_d  = bcd_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (clear) begin
      ps_d  = '0;
      bcd_d = '0;
    end else if (enable) begin
      if (ps_q == PS_LAST) begin
        ps_d   = '0;
        tick_d = 1'b1;
        if (!all_nines) begin
          bcd_d = bcd_inc(bcd_q);
        end else if (!saturate) begin
          bcd_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        ps_d = ps_q + PW'(1);
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples its pre-edge value, independent of statement order.
    if (reset) begin
      ps_q   <= '0;
      bcd_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      bcd_q  <= bcd_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign bcd       = bcd_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;
  assign at_max    = all_nines;
  assign fast_slow = bcd_q[4*LEVEL_DIGIT];

`ifdef BCD_GAME_TIMER_HEX_EN
  // Active-low segment code {g,f,e,d,c,b,a}; non-decimal values show blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h18;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    assign hex[7*g +: 7] = seg7(bcd_q[4*g +: 4]);
  end
`else
  assign hex = '1;
`endif

endmodule

// File: tb/tb_bcd_game_timer.sv
// Directed bench for bcd_game_timer with TICK_DIV=4. It uses a 4-digit
// instance (u4) and a 2-digit instance (u2). Both share the clock and the
// reset, and each has its own control inputs.
module tb_bcd_game_timer;

  logic clk = 1'b0;
  logic rst;
  logic en4, clr4, sat4;
  logic en2, clr2, sat2;

  logic [15:0] bcd4;
  logic        tick4, wrap4, atmax4, fs4;
  logic [27:0] hex4;
  logic [7:0]  bcd2;
  logic        tick2, wrap2, atmax2, fs2;
  logic [13:0] hex2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_game_timer #(.DIGITS(4), .TICK_DIV(4), .LEVEL_DIGIT(1)) u4 (
    .CLOCK_50(clk), .reset(rst), .enable(en4), .clear(clr4), .saturate(sat4),
    .bcd(bcd4), .tick(tick4), .wrap(wrap4), .at_max(atmax4),
    .fast_slow(fs4), .hex(hex4)
  );

  bcd_game_timer #(.DIGITS(2), .TICK_DIV(4), .LEVEL_DIGIT(1)) u2 (
    .CLOCK_50(clk), .reset(rst), .enable(en2), .clear(clr2), .saturate(sat2),
    .bcd(bcd2), .tick(tick2), .wrap(wrap2), .at_max(atmax2),
    .fast_slow(fs2), .hex(hex2)
  );

  // Expected segment code per digit, written out from the encoding table.
  function automatic logic [6:0] seg(input logic [3:0] d);
`ifdef BCD_GAME_TIMER_HEX_EN
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h18;
      default: return 7'h7F;
    endcase
`else
    return 7'h7F;
`endif
  endfunction

  function automatic logic [27:0] exp_hex(input logic [15:0] v, input int nd);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) r[7*i +: 7] = seg(v[4*i +: 4]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock edge, then settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          cyc;
    logic [15:0] bcd;
    logic        tick;
    logic        fs;
  } vec_t;

  vec_t vecs[10];
  int   cyc, ticks, wraps;

  initial begin
    // Checkpoints measured in enabled edges after reset release.
    vecs[0] = '{cyc: 1,   bcd: 16'h0000, tick: 1'b0, fs: 1'b0};
    vecs[1] = '{cyc: 3,   bcd: 16'h0000, tick: 1'b0, fs: 1'b0};
    vecs[2] = '{cyc: 4,   bcd: 16'h0001, tick: 1'b1, fs: 1'b0};
    vecs[3] = '{cyc: 5,   bcd: 16'h0001, tick: 1'b0, fs: 1'b0};
    vecs[4] = '{cyc: 36,  bcd: 16'h0009, tick: 1'b1, fs: 1'b0};
    vecs[5] = '{cyc: 39,  bcd: 16'h0009, tick: 1'b0, fs: 1'b0};
    vecs[6] = '{cyc: 40,  bcd: 16'h0010, tick: 1'b1, fs: 1'b1};
    vecs[7] = '{cyc: 41,  bcd: 16'h0010, tick: 1'b0, fs: 1'b1};
    vecs[8] = '{cyc: 80,  bcd: 16'h0020, tick: 1'b1, fs: 1'b0};
    vecs[9] = '{cyc: 120, bcd: 16'h0030, tick: 1'b1, fs: 1'b1};

    rst = 1'b1;
    en4 = 1'b0; clr4 = 1'b0; sat4 = 1'b0;
    en2 = 1'b0; clr2 = 1'b0; sat2 = 1'b0;
    #1;
    check("rst_bcd",    64'(bcd4),   64'h0);
    check("rst_tick",   64'(tick4),  64'h0);
    check("rst_wrap",   64'(wrap4),  64'h0);
    check("rst_at_max", 64'(atmax4), 64'h0);
    check("rst_fs",     64'(fs4),    64'h0);
    check("rst_hex",    64'(hex4),   64'(exp_hex(16'h0000, 4)));

    // Counting from reset, checked against the checkpoint table.
    step();
    rst = 1'b0;
    en4 = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      while (cyc < vecs[i].cyc) begin
        step();
        cyc++;
        check("s1_tick_cadence", 64'(tick4), 64'((cyc % 4) == 0));
      end
      check("s1_bcd",  64'(bcd4), 64'(vecs[i].bcd));
      check("s1_tick", 64'(tick4), 64'(vecs[i].tick));
      check("s1_fs",   64'(fs4),  64'(vecs[i].fs));
      check("s1_hex",  64'(hex4), 64'(exp_hex(vecs[i].bcd, 4)));
    end

    // Pause for 10 cycles while the prescaler sits at 2.
    step(); step();
    en4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("s4_pause_tick", 64'(tick4), 64'h0);
    end
    check("s4_pause_bcd", 64'(bcd4), 64'h0030);
    en4 = 1'b1;
    step();
    check("s4_pre_tick", 64'(tick4), 64'h0);
    step();
    check("s4_tick", 64'(tick4), 64'h1);
    check("s4_bcd",  64'(bcd4),  64'h0031);

    // Clear takes priority over a pending increment from 0009.
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    check("s5_clr0_bcd", 64'(bcd4), 64'h0000);
    for (int i = 0; i < 39; i++) step();
    check("s5_at9_bcd", 64'(bcd4), 64'h0009);
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    check("s5_clr_bcd",  64'(bcd4),  64'h0000);
    check("s5_clr_tick", 64'(tick4), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("s5_wait_tick", 64'(tick4), 64'h0);
    end
    step();
    check("s5_tick", 64'(tick4), 64'h1);
    check("s5_bcd",  64'(bcd4),  64'h0001);

    // Asynchronous reset at 0123, asserted between edges.
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    for (int i = 0; i < 492; i++) step();
    check("s6_pre_bcd", 64'(bcd4), 64'h0123);
    check("s6_pre_hex", 64'(hex4), 64'(exp_hex(16'h0123, 4)));
    #2;
    rst = 1'b1;
    #1;
    check("s6_async_bcd", 64'(bcd4), 64'h0000);
    check("s6_async_hex", 64'(hex4), 64'(exp_hex(16'h0000, 4)));
    check("s6_async_fs",  64'(fs4),  64'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("s6_resume_wait", 64'(bcd4), 64'h0000);
    step();
    check("s6_resume_bcd",  64'(bcd4),  64'h0001);
    check("s6_resume_tick", 64'(tick4), 64'h1);

    // Two-digit wrap with saturate=0.
    en4 = 1'b0;
    en2 = 1'b1;
    wraps = 0;
    for (int i = 0; i < 396; i++) begin
      step();
      if (wrap2) wraps++;
    end
    check("s2_99_bcd",    64'(bcd2),   64'h99);
    check("s2_99_at_max", 64'(atmax2), 64'h1);
    check("s2_99_fs",     64'(fs2),    64'h1);
    check("s2_99_hex",    64'(hex2),   64'(exp_hex(16'h0099, 2)));
    check("s2_no_early_wrap", 64'(wraps), 64'h0);
    for (int i = 0; i < 3; i++) step();
    check("s2_hold_at_max", 64'(atmax2), 64'h1);
    step();
    check("s2_wrap_bcd",  64'(bcd2),   64'h00);
    check("s2_wrap",      64'(wrap2),  64'h1);
    check("s2_wrap_tick", 64'(tick2),  64'h1);
    check("s2_wrap_max",  64'(atmax2), 64'h0);
    step();
    check("s2_wrap_end", 64'(wrap2), 64'h0);

    // Two-digit saturation: 120 counts from zero.
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    sat2 = 1'b1;
    wraps = 0;
    ticks = 0;
    for (int i = 0; i < 480; i++) begin
      step();
      if (wrap2) wraps++;
      if (tick2) ticks++;
    end
    check("s3_bcd",    64'(bcd2),   64'h99);
    check("s3_at_max", 64'(atmax2), 64'h1);
    check("s3_wraps",  64'(wraps),  64'h0);
    check("s3_ticks",  64'(ticks),  64'd120);
    check("s3_tick",   64'(tick2),  64'h1);

    // Dropping saturate does not disturb the held value until the next count.
    sat2 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("s3_held_bcd", 64'(bcd2), 64'h99);
    step();
    check("s3_late_wrap_bcd", 64'(bcd2),  64'h00);
    check("s3_late_wrap",     64'(wrap2), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
